channel_requester: RTL and testbench
====================================

Name: channel_requester

Overview:
Initiator side of the memory channel req/ack protocol. Accepts commands from an upstream agent through a small command FIFO and drives them one at a time onto a channel controller. It holds address, data and direction stable until ack, captures read data, and returns one response per command through a valid/ready port. Includes a request timeout with an error response and a saturating timeout counter.

Parameters:
ADDR_WIDTH, 32, channel address width
DATA_WIDTH, 64, channel data width
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT_CYCLES, 16, max cycles req is held without ack (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  upstream command valid
cmd_ready  out  1  FIFO not full
cmd_addr  in  ADDR_WIDTH  command address
cmd_wdata  in  DATA_WIDTH  command write data
cmd_wr  in  1  1=write, 0=read
req  out  1  channel request
addr  out  ADDR_WIDTH  channel address
wdata  out  DATA_WIDTH  channel write data
wr_en  out  1  channel direction
ack  in  1  channel acknowledge (single-cycle pulse)
rdata  in  DATA_WIDTH  channel read data
valid  in  1  channel read data valid (with ack, reads only)
rsp_valid  out  1  response valid
rsp_ready  in  1  upstream accepts response
rsp_addr  out  ADDR_WIDTH  address of completed command
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
rsp_wr  out  1  direction of completed command
rsp_err  out  1  1 = timed out
fifo_level  out  $clog2(FIFO_DEPTH)+1  commands queued
busy  out  1  state != IDLE or FIFO non-empty
timeout_count  out  16  saturating timeout count

Behaviour:
- Reset (async): all outputs 0 and cmd_ready=1. FIFO emptied. FSM goes to IDLE. Any in-flight transaction and pending response are discarded. req drops immediately on reset assertion.
- FIFO: push on cmd_valid&&cmd_ready. cmd_ready = !full (registered-state based). Push and pop in the same cycle are allowed and leave the level unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if FIFO non-empty, at the next edge pop the head, load addr/wdata/wr_en, set req=1, clear the timeout counter, and go to ISSUE.
- ISSUE:
  - req, addr, wdata and wr_en are held constant.
  - The timeout counter increments every cycle.
  - On a sampled ack: req<=0 and go to RESP. rsp_rdata<=rdata if !wr_en&&valid, else 0. rsp_err<=0. rsp_valid<=1.
  - If there is no ack for TIMEOUT_CYCLES sampled edges since req rose: at the TIMEOUT_CYCLES-th edge, req<=0, rsp_err<=1, rsp_rdata<=0, rsp_valid<=1, timeout_count increments (saturates at 0xFFFF), and go to RESP.
  - If ack and timeout fall on the same edge, ack wins (no error).
- RESP: hold rsp_* until rsp_valid&&rsp_ready, then rsp_valid<=0 and go to IDLE. req is low in RESP, which guarantees at least 2 low cycles between requests so the controller returns to idle.
- rsp_addr and rsp_wr are copies of the issued command.
- Stray ack (in IDLE or RESP, e.g. a late ack after a timeout) is ignored and has no state change.
- valid without ack is ignored. valid with ack on a write is ignored (rsp_rdata=0).
- addr/wdata/wr_en retain their last values when req=0.
- Responses are returned in command order; only one is outstanding at a time.
- Timing: command-to-req is 2 edges from push into an empty FIFO with the FSM in IDLE. ack-to-rsp_valid is 1 edge.

Test Plan:
- Single read: push addr=0x10, wr=0. Responder acks 5 cycles after req with valid=1, rdata=0xAB. Expect req held 5 cycles with addr=0x10 stable, then rsp_valid=1, rsp_rdata=0xAB, rsp_err=0, rsp_wr=0.
- Write: push addr=0x20, wdata=0x55, wr=1. Responder acks with valid=0. Expect wr_en=1 and wdata=0x55 during req, then rsp_rdata=0, rsp_wr=1.
- FIFO full and backpressure: push 5 commands back-to-back with rsp_ready=0. Expect cmd_ready=0 after 4 are queued (one in flight), fifo_level=4. Then release rsp_ready and expect 5 in-order responses, with req low for at least 2 cycles between requests.
- Timeout: the responder never acks (TIMEOUT_CYCLES=16). Expect req to drop after 16 cycles, rsp_err=1, timeout_count=1. A late ack 3 cycles later is ignored and the next command issues normally.
- Boundary: ack arrives on the 16th cycle of req. Expect a normal response with rsp_err=0 and timeout_count unchanged.
- Reset mid-ISSUE: assert rst_n=0 while req=1 and 2 commands are queued. Expect req=0 immediately, fifo_level=0, rsp_valid=0, and cmd_ready=1 after release.

Source files
------------

// File: rtl/channel_requester.sv
// Initiator side of the memory-channel req/ack protocol: command FIFO feeding a
// single-outstanding request engine with timeout and a valid/ready response port.
module channel_requester #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [DATA_WIDTH-1:0]         cmd_wdata,
  input  logic                          cmd_wr,
  output logic                          req,
  output logic [ADDR_WIDTH-1:0]         addr,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          wr_en,
  input  logic                          ack,
  input  logic [DATA_WIDTH-1:0]         rdata,
  input  logic                          valid,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ADDR_WIDTH-1:0]         rsp_addr,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_wr,
  output logic                          rsp_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic [15:0]                   timeout_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = ADDR_WIDTH + DATA_WIDTH + 1;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t                r_state;
  logic [FW-1:0]         r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [PW:0]           r_count;
  logic [TW-1:0]         r_tcnt;
  logic [15:0]           r_tocnt;
  logic                  r_req;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_wr_en;
  logic                  r_rsp_valid;
  logic [ADDR_WIDTH-1:0] r_rsp_addr;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_wr;
  logic                  r_rsp_err;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [FW-1:0]         w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);
  assign w_push  = cmd_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  assign w_head  = r_mem[r_rptr];

  // Storage needs no reset; occupancy is tracked by the reset pointers/count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {cmd_wr, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_state     <= S_IDLE;
      r_tcnt      <= '0;
      r_tocnt     <= '0;
      r_req       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wr_en     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_rdata <= '0;
      r_rsp_wr    <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase

      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            {r_wr_en, r_addr, r_wdata} <= w_head;
            r_req   <= 1'b1;
            r_tcnt  <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // ack has priority over a timeout landing on the same edge
          if (ack) begin
            r_req       <= 1'b0;
            r_rsp_rdata <= (!r_wr_en && valid) ? rdata : '0;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_addr  <= r_addr;
            r_rsp_wr    <= r_wr_en;
            r_state     <= S_RESP;
          end else if (r_tcnt == T_LAST) begin
            r_req       <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_addr  <= r_addr;
            r_rsp_wr    <= r_wr_en;
            if (r_tocnt != '1) r_tocnt <= r_tocnt + 16'd1;
            r_state     <= S_RESP;
          end else begin
            r_tcnt <= r_tcnt + T_ONE;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready     = !w_full;
  assign req           = r_req;
  assign addr          = r_addr;
  assign wdata         = r_wdata;
  assign wr_en         = r_wr_en;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_addr      = r_rsp_addr;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_wr        = r_rsp_wr;
  assign rsp_err       = r_rsp_err;
  assign fifo_level    = r_count;
  assign busy          = (r_state != S_IDLE) || !w_empty;
  assign timeout_count = r_tocnt;

endmodule

// File: tb/tb_channel_requester.sv
// Scoreboard bench for channel_requester: behavioural channel responder plus
// per-scenario tasks that push expected responses and compare them on return.
`timescale 1ns/1ps
module tb_channel_requester;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int FD = 4;
  localparam int TO = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0]        cmd_addr;
  logic [DW-1:0]        cmd_wdata;
  logic                 req, wr_en, ack, valid;
  logic [AW-1:0]        addr;
  logic [DW-1:0]        wdata, rdata;
  logic                 rsp_valid, rsp_ready, rsp_wr, rsp_err, busy;
  logic [AW-1:0]        rsp_addr;
  logic [DW-1:0]        rsp_rdata;
  logic [$clog2(FD):0]  fifo_level;
  logic [15:0]          timeout_count;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [15:0] exp_tcount = '0;

  // responder controls (written only by the main sequence)
  int ack_delay      = 5;
  bit resp_never     = 0;
  bit valid_on_write = 0;
  int stray_req      = 0;
  // written only by the responder / monitor
  int stray_done     = 0;
  int gap_viol       = 0;

  channel_requester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wr(cmd_wr),
    .req(req), .addr(addr), .wdata(wdata), .wr_en(wr_en),
    .ack(ack), .rdata(rdata), .valid(valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_rdata(rsp_rdata), .rsp_wr(rsp_wr), .rsp_err(rsp_err),
    .fifo_level(fifo_level), .busy(busy), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    return (a == 32'h10) ? 64'hAB : {32'hFEED_0000, a};
  endfunction

  // Channel responder: acks ack_delay cycles after req rises, or injects stray acks.
  initial begin
    int hi;
    hi = 0; ack = 0; valid = 0; rdata = '0;
    forever begin
      @(posedge clk); #1;
      ack = 0; valid = 0;
      if (req === 1'b1) hi++; else hi = 0;
      if (stray_req != stray_done) begin
        ack = 1; valid = 1; rdata = 64'hDEAD_BEEF; stray_done++;
      end else if (req === 1'b1 && !resp_never && hi == ack_delay) begin
        ack = 1; valid = !wr_en || valid_on_write; rdata = rd_model(addr);
      end
    end
  end

  // Counts requests that rise after fewer than two low cycles.
  initial begin
    int low_run;
    bit prev;
    low_run = 100; prev = 0;
    forever begin
      @(posedge clk); #1;
      if (req === 1'b1 && !prev && low_run < 2) gap_viol++;
      if (req === 1'b1) low_run = 0; else low_run++;
      prev = (req === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 200000", $time);
    $fatal(1);
  end

  task automatic push_cmd(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic w, input logic err);
    exp_t e;
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    cmd_valid = 1; cmd_addr = a; cmd_wdata = d; cmd_wr = w;
    @(posedge clk); #1;
    cmd_valid = 0;
    e.addr = a; e.wr = w; e.err = err;
    e.rdata = (w || err) ? '0 : rd_model(a);
    sb.push_back(e);
  endtask

  task automatic get_rsp(output bit ok, output exp_t got);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    ok = (rsp_valid === 1'b1);
    got.addr = rsp_addr; got.wr = rsp_wr; got.rdata = rsp_rdata; got.err = rsp_err;
    if (ok) begin
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
    end
  endtask

  task automatic track_req(output int hi, output bit stable);
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          w0;
    a0 = addr; d0 = wdata; w0 = wr_en;
    hi = 0; stable = 1;
    while (req === 1'b1 && hi < 100) begin
      hi++;
      if (addr !== a0 || wdata !== d0 || wr_en !== w0) stable = 0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 0; cmd_valid = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wr = 0; rsp_ready = 0;
    #12;
    compared++;
    if (req !== 0 || rsp_valid !== 0 || cmd_ready !== 1 || fifo_level !== '0 ||
        busy !== 0 || timeout_count !== 16'd0 || addr !== '0 || rsp_rdata !== '0) begin
      mismatched++;
      $display("FAIL reset_state: req=%b rsp_valid=%b cmd_ready=%b level=%0d busy=%b tcount=%0d, required 0,0,1,0,0,0",
               req, rsp_valid, cmd_ready, fifo_level, busy, timeout_count);
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    int hi; bit stable, ok; exp_t got, e;
    ack_delay = 5; resp_never = 0;
    push_cmd(32'h10, 64'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    compared++;
    if (req !== 1 || addr !== 32'h10 || wr_en !== 0) begin
      mismatched++;
      $display("FAIL read_issue: req=%b addr=%h wr_en=%b, required 1 00000010 0", req, addr, wr_en);
    end
    track_req(hi, stable);
    compared++;
    if (hi != 5 || !stable) begin
      mismatched++;
      $display("FAIL read_req_window: cycles=%0d stable=%b, required 5 1", hi, stable);
    end
    compared++;
    if (rsp_valid !== 1) begin
      mismatched++;
      $display("FAIL read_rsp_latency: rsp_valid=%b, required 1", rsp_valid);
    end
    get_rsp(ok, got); e = sb.pop_front();
    compared++;
    if (!ok || got !== e) begin
      mismatched++;
      $display("FAIL read_rsp: got addr=%h wr=%b rdata=%h err=%b ok=%b, required addr=%h wr=%b rdata=%h err=%b",
               got.addr, got.wr, got.rdata, got.err, ok, e.addr, e.wr, e.rdata, e.err);
    end
  endtask

  task automatic test_write();
    int hi; bit stable, ok; exp_t got, e;
    ack_delay = 3;
    push_cmd(32'h20, 64'h55, 1'b1, 1'b0);
    @(posedge clk); #1;
    compared++;
    if (req !== 1 || addr !== 32'h20 || wr_en !== 1 || wdata !== 64'h55) begin
      mismatched++;
      $display("FAIL write_issue: req=%b addr=%h wr_en=%b wdata=%h, required 1 00000020 1 55",
               req, addr, wr_en, wdata);
    end
    track_req(hi, stable);
    compared++;
    if (hi != 3 || !stable) begin
      mismatched++;
      $display("FAIL write_req_window: cycles=%0d stable=%b, required 3 1", hi, stable);
    end
    get_rsp(ok, got); e = sb.pop_front();
    compared++;
    if (!ok || got !== e) begin
      mismatched++;
      $display("FAIL write_rsp: got addr=%h wr=%b rdata=%h err=%b ok=%b, required addr=%h wr=%b rdata=%h err=%b",
               got.addr, got.wr, got.rdata, got.err, ok, e.addr, e.wr, e.rdata, e.err);
    end
  endtask

  task automatic test_back_to_back();
    bit ok; exp_t got, e; int g0;
    logic [AW-1:0] a; logic w;
    rsp_ready = 0; ack_delay = 2; valid_on_write = 1;
    g0 = gap_viol;
    for (int i = 0; i < 5; i++) begin
      a = 32'h100 + 32'(i * 4); w = i[0];
      compared++;
      if (cmd_ready !== 1) begin
        mismatched++;
        $display("FAIL fifo_accept_%0d: cmd_ready=%b, required 1", i, cmd_ready);
      end
      cmd_valid = 1; cmd_addr = a; cmd_wdata = 64'h1000 + 64'(i); cmd_wr = w;
      @(posedge clk); #1;
      e.addr = a; e.wr = w; e.err = 0; e.rdata = w ? '0 : rd_model(a);
      sb.push_back(e);
    end
    cmd_valid = 0;
    compared++;
    if (cmd_ready !== 0 || fifo_level !== 3'd4 || busy !== 1) begin
      mismatched++;
      $display("FAIL fifo_full: cmd_ready=%b level=%0d busy=%b, required 0 4 1", cmd_ready, fifo_level, busy);
    end
    repeat (4) @(posedge clk); #1;
    compared++;
    if (fifo_level !== 3'd4 || rsp_valid !== 1 || req !== 0) begin
      mismatched++;
      $display("FAIL fifo_backpressure: level=%0d rsp_valid=%b req=%b, required 4 1 0", fifo_level, rsp_valid, req);
    end
    for (int i = 0; i < 5; i++) begin
      get_rsp(ok, got); e = sb.pop_front();
      compared++;
      if (!ok || got !== e) begin
        mismatched++;
        $display("FAIL order_rsp_%0d: got addr=%h wr=%b rdata=%h err=%b ok=%b, required addr=%h wr=%b rdata=%h err=%b",
                 i, got.addr, got.wr, got.rdata, got.err, ok, e.addr, e.wr, e.rdata, e.err);
      end
    end
    compared++;
    if (gap_viol != g0) begin
      mismatched++;
      $display("FAIL req_gap: short gaps=%0d, required 0", gap_viol - g0);
    end
    valid_on_write = 0;
  endtask

  task automatic test_timeout();
    int hi; bit stable, ok; exp_t got, e;
    resp_never = 1;
    push_cmd(32'h30, 64'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    track_req(hi, stable);
    exp_tcount++;
    compared++;
    if (hi != TO || rsp_valid !== 1 || rsp_err !== 1 || timeout_count !== exp_tcount) begin
      mismatched++;
      $display("FAIL timeout: cycles=%0d rsp_valid=%b err=%b tcount=%0d, required %0d 1 1 %0d",
               hi, rsp_valid, rsp_err, timeout_count, TO, exp_tcount);
    end
    repeat (2) @(posedge clk); #1;
    stray_req++;
    repeat (3) @(posedge clk); #1;
    compared++;
    if (rsp_valid !== 1 || rsp_err !== 1 || req !== 0 || timeout_count !== exp_tcount) begin
      mismatched++;
      $display("FAIL stray_ack_resp: rsp_valid=%b err=%b req=%b tcount=%0d, required 1 1 0 %0d",
               rsp_valid, rsp_err, req, timeout_count, exp_tcount);
    end
    get_rsp(ok, got); e = sb.pop_front();
    compared++;
    if (!ok || got !== e) begin
      mismatched++;
      $display("FAIL timeout_rsp: got addr=%h wr=%b rdata=%h err=%b ok=%b, required addr=%h wr=%b rdata=%h err=%b",
               got.addr, got.wr, got.rdata, got.err, ok, e.addr, e.wr, e.rdata, e.err);
    end
    stray_req++;
    repeat (3) @(posedge clk); #1;
    compared++;
    if (busy !== 0 || req !== 0 || rsp_valid !== 0) begin
      mismatched++;
      $display("FAIL stray_ack_idle: busy=%b req=%b rsp_valid=%b, required 0 0 0", busy, req, rsp_valid);
    end
    resp_never = 0; ack_delay = 4;
    push_cmd(32'h34, 64'h0, 1'b0, 1'b0);
    get_rsp(ok, got); e = sb.pop_front();
    compared++;
    if (!ok || got !== e || timeout_count !== exp_tcount) begin
      mismatched++;
      $display("FAIL after_timeout_rsp: got addr=%h rdata=%h err=%b tcount=%0d ok=%b, required addr=%h rdata=%h err=%b tcount=%0d",
               got.addr, got.rdata, got.err, timeout_count, ok, e.addr, e.rdata, e.err, exp_tcount);
    end
  endtask

  task automatic test_boundary();
    int hi; bit stable, ok; exp_t got, e;
    resp_never = 0; ack_delay = TO;
    push_cmd(32'h40, 64'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    track_req(hi, stable);
    compared++;
    if (hi != TO || rsp_valid !== 1 || rsp_err !== 0 || timeout_count !== exp_tcount) begin
      mismatched++;
      $display("FAIL boundary_ack: cycles=%0d rsp_valid=%b err=%b tcount=%0d, required %0d 1 0 %0d",
               hi, rsp_valid, rsp_err, timeout_count, TO, exp_tcount);
    end
    get_rsp(ok, got); e = sb.pop_front();
    compared++;
    if (!ok || got !== e) begin
      mismatched++;
      $display("FAIL boundary_rsp: got addr=%h wr=%b rdata=%h err=%b ok=%b, required addr=%h wr=%b rdata=%h err=%b",
               got.addr, got.wr, got.rdata, got.err, ok, e.addr, e.wr, e.rdata, e.err);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; exp_t got, e;
    resp_never = 1;
    push_cmd(32'h60, 64'h0, 1'b0, 1'b1);
    push_cmd(32'h64, 64'h0, 1'b0, 1'b1);
    push_cmd(32'h68, 64'h0, 1'b0, 1'b1);
    compared++;
    if (req !== 1 || fifo_level !== 3'd2) begin
      mismatched++;
      $display("FAIL pre_reset: req=%b level=%0d, required 1 2", req, fifo_level);
    end
    #2; rst_n = 0; #1;
    compared++;
    if (req !== 0 || fifo_level !== '0 || rsp_valid !== 0 || busy !== 0 || timeout_count !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_mid: req=%b level=%0d rsp_valid=%b busy=%b tcount=%0d, required 0 0 0 0 0",
               req, fifo_level, rsp_valid, busy, timeout_count);
    end
    sb.delete(); exp_tcount = '0;
    #3; rst_n = 1;
    @(posedge clk); #1;
    compared++;
    if (cmd_ready !== 1 || req !== 0) begin
      mismatched++;
      $display("FAIL post_reset: cmd_ready=%b req=%b, required 1 0", cmd_ready, req);
    end
    resp_never = 0; ack_delay = 1;
    push_cmd(32'h70, 64'h0, 1'b0, 1'b0);
    get_rsp(ok, got); e = sb.pop_front();
    compared++;
    if (!ok || got !== e) begin
      mismatched++;
      $display("FAIL post_reset_rsp: got addr=%h wr=%b rdata=%h err=%b ok=%b, required addr=%h wr=%b rdata=%h err=%b",
               got.addr, got.wr, got.rdata, got.err, ok, e.addr, e.wr, e.rdata, e.err);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_timeout();
    test_boundary();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
